// File: rtl/spi_controller_mm.sv
// SPI controller: single-word full-duplex or write-pause-read transfers to one of CS_COUNT peripherals.
// Latency: done rises CLK_DIV*(2N+2) cycles after acceptance (N = SCLK periods incl. pause); a rejected request answers in 1 cycle.
// No backpressure: a request is taken only in IDLE, and start_comm while busy is ignored.
module spi_controller_mm #(
    parameter int DATA_W   = 16,
    parameter int LEN_W    = 5,
    parameter int CS_COUNT = 4,
    parameter int CS_W     = 2,
    parameter int CLK_DIV  = 2,
    parameter int PAUSE    = 5
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start_comm,
    input  logic [CS_W-1:0]     CS_in,
    input  logic                cpol,
    input  logic                cpha,
    input  logic                duplex,
    input  logic [LEN_W-1:0]    tx_bits,
    input  logic [LEN_W-1:0]    rx_bits,
    input  logic [DATA_W-1:0]   data_tx,
    input  logic                CIPO,
    output logic                SCLK,
    output logic                COPI,
    output logic [CS_COUNT-1:0] CS_n,
    output logic [DATA_W-1:0]   data_rx,
    output logic                busy,
    output logic                done,
    output logic                err
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_SETUP = 3'd1;
    localparam logic [2:0] S_WRITE = 3'd2;
    localparam logic [2:0] S_PAUSE = 3'd3;
    localparam logic [2:0] S_READ  = 3'd4;
    localparam logic [2:0] S_HOLD  = 3'd5;

    localparam int DIV_W    = $clog2(CLK_DIV + 1);
    localparam int PAUSE_CW = $clog2(PAUSE + 1);
    localparam int CNT_W    = (LEN_W > PAUSE_CW) ? LEN_W : PAUSE_CW;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [LEN_W-1:0] DATA_W_L = LEN_W'(DATA_W);
    localparam logic [CNT_W-1:0] PAUSE_L  = CNT_W'(PAUSE);

    logic [2:0]        state;
    logic [DIV_W-1:0]  div_cnt;
    logic              phase;      // 0: next half-period tick is a leading edge, 1: trailing
    logic [CNT_W-1:0]  per_cnt;    // SCLK periods left in the current phase
    logic [DATA_W-1:0] tx_sr;
    logic [DATA_W-1:0] rx_sr;
    logic              cpha_r;
    logic              duplex_r;
    logic [LEN_W-1:0]  rx_bits_r;

    logic              tick;
    logic              lead_tick;
    logic              trail_tick;
    logic              shift_edge;
    logic              sample_edge;
    logic              last_per;
    logic              req_bad;
    logic [LEN_W-1:0]  tx_shamt;
    logic [DATA_W-1:0] tx_align;

    // Half-period timing, edge classification and request validation.
    always_comb begin
        tick        = (state != S_IDLE) && (div_cnt == DIV_LAST);
        lead_tick   = tick && !phase;
        trail_tick  = tick && phase;
        shift_edge  = cpha_r ? lead_tick : trail_tick;
        sample_edge = cpha_r ? trail_tick : lead_tick;
        last_per    = (per_cnt == CNT_W'(1));
        req_bad     = (tx_bits == '0) || (tx_bits > DATA_W_L) ||
                      (!duplex && ((rx_bits == '0) || (rx_bits > DATA_W_L)));
        tx_shamt    = DATA_W_L - tx_bits;
        // MSB-align the word so the first bit to send sits at the top of the shifter.
        tx_align    = data_tx << tx_shamt;
    end

    // Transfer sequencer: owns the state, SCLK/COPI/CS_n generation, shifters and status pulses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            div_cnt   <= '0;
            phase     <= 1'b0;
            per_cnt   <= '0;
            tx_sr     <= '0;
            rx_sr     <= '0;
            cpha_r    <= 1'b0;
            duplex_r  <= 1'b0;
            rx_bits_r <= '0;
            SCLK      <= 1'b0;
            COPI      <= 1'b0;
            CS_n      <= '1;
            data_rx   <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            if (state != S_IDLE) begin
                div_cnt <= tick ? '0 : div_cnt + 1'b1;
            end
            case (state)
                S_IDLE: begin
                    SCLK    <= cpol;
                    div_cnt <= '0;
                    if (start_comm) begin
                        if (req_bad) begin
                            done <= 1'b1;
                            err  <= 1'b1;
                        end else begin
                            state     <= S_SETUP;
                            busy      <= 1'b1;
                            CS_n      <= ~(CS_COUNT'(1) << CS_in);
                            cpha_r    <= cpha;
                            duplex_r  <= duplex;
                            rx_bits_r <= rx_bits;
                            per_cnt   <= CNT_W'(tx_bits);
                            phase     <= 1'b0;
                            rx_sr     <= '0;
                            // cpha=0 presents the first bit during SETUP; cpha=1 waits for the leading edge.
                            if (cpha) begin
                                tx_sr <= tx_align;
                                COPI  <= 1'b0;
                            end else begin
                                tx_sr <= tx_align << 1;
                                COPI  <= tx_align[DATA_W-1];
                            end
                        end
                    end
                end
                S_SETUP: begin
                    if (tick) begin
                        state <= S_WRITE;
                    end
                end
                S_WRITE, S_PAUSE, S_READ: begin
                    if (tick) begin
                        phase <= ~phase;
                        if (state != S_PAUSE) begin
                            SCLK <= ~SCLK;
                        end
                        if ((state == S_WRITE) && shift_edge) begin
                            COPI  <= tx_sr[DATA_W-1];
                            tx_sr <= tx_sr << 1;
                        end
                        if (sample_edge && ((state == S_READ) || ((state == S_WRITE) && duplex_r))) begin
                            rx_sr <= {rx_sr[DATA_W-2:0], CIPO};
                        end
                        if (trail_tick) begin
                            per_cnt <= per_cnt - 1'b1;
                            if (last_per) begin
                                if (state == S_WRITE) begin
                                    COPI <= 1'b0;
                                    if (duplex_r) begin
                                        state <= S_HOLD;
                                    end else if (PAUSE == 0) begin
                                        state   <= S_READ;
                                        per_cnt <= CNT_W'(rx_bits_r);
                                    end else begin
                                        state   <= S_PAUSE;
                                        per_cnt <= PAUSE_L;
                                    end
                                end else if (state == S_PAUSE) begin
                                    state   <= S_READ;
                                    per_cnt <= CNT_W'(rx_bits_r);
                                end else begin
                                    state <= S_HOLD;
                                end
                            end
                        end
                    end
                end
                S_HOLD: begin
                    if (tick) begin
                        state   <= S_IDLE;
                        done    <= 1'b1;
                        busy    <= 1'b0;
                        CS_n    <= '1;
                        data_rx <= rx_sr;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spi_controller_mm.sv
// Testbench for spi_controller_mm: directed table plus random transfers against a behavioural SPI peripheral.
// Latency: checks done timing against CLK_DIV*(2N+2) from the accepting edge.
// No backpressure in the DUT; the bench re-pokes start_comm mid-transfer to confirm it is ignored.
module tb_spi_controller_mm;
    localparam int DATA_W   = 16;
    localparam int LEN_W    = 5;
    localparam int CS_COUNT = 4;
    localparam int CS_W     = 2;
    localparam int CLK_DIV  = 2;
    localparam int PAUSE    = 5;

    logic                clk = 1'b0;
    logic                rst;
    logic                start_comm;
    logic [CS_W-1:0]     CS_in;
    logic                cpol;
    logic                cpha;
    logic                duplex;
    logic [LEN_W-1:0]    tx_bits;
    logic [LEN_W-1:0]    rx_bits;
    logic [DATA_W-1:0]   data_tx;
    logic                CIPO;
    logic                SCLK;
    logic                COPI;
    logic [CS_COUNT-1:0] CS_n;
    logic [DATA_W-1:0]   data_rx;
    logic                busy;
    logic                done;
    logic                err;

    spi_controller_mm #(
        .DATA_W(DATA_W), .LEN_W(LEN_W), .CS_COUNT(CS_COUNT),
        .CS_W(CS_W), .CLK_DIV(CLK_DIV), .PAUSE(PAUSE)
    ) dut (
        .clk(clk), .rst(rst), .start_comm(start_comm), .CS_in(CS_in),
        .cpol(cpol), .cpha(cpha), .duplex(duplex), .tx_bits(tx_bits),
        .rx_bits(rx_bits), .data_tx(data_tx), .CIPO(CIPO), .SCLK(SCLK),
        .COPI(COPI), .CS_n(CS_n), .data_rx(data_rx), .busy(busy),
        .done(done), .err(err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: actual 0x%0h required 0x%0h", name, act, exp);
        end
    endtask

    typedef struct {
        bit [1:0] cs;
        bit       cpol;
        bit       cpha;
        bit       duplex;
        int       txb;
        int       rxb;
        longint   txd;
        longint   resp;
        bit       exp_err;
        longint   exp_rx;
        int       exp_lat;
        longint   exp_rcv;
        string    name;
    } vec_t;

    function automatic vec_t mk(input bit [1:0] cs, input bit cp, input bit ch, input bit dup,
                                input int txb, input int rxb, input longint txd, input longint resp,
                                input bit ee, input longint erx, input int lat, input longint ercv,
                                input string nm);
        vec_t v;
        v.cs = cs; v.cpol = cp; v.cpha = ch; v.duplex = dup;
        v.txb = txb; v.rxb = rxb; v.txd = txd; v.resp = resp;
        v.exp_err = ee; v.exp_rx = erx; v.exp_lat = lat; v.exp_rcv = ercv; v.name = nm;
        return v;
    endfunction

    // Reference: what a correct transfer produces, from bit counts and plain arithmetic.
    function automatic vec_t model(input vec_t v);
        vec_t   r  = v;
        longint tm = (longint'(1) << v.txb) - 1;
        longint rm = (longint'(1) << v.rxb) - 1;
        r.exp_err = (v.txb == 0) || (v.txb > DATA_W) ||
                    (!v.duplex && ((v.rxb == 0) || (v.rxb > DATA_W)));
        if (v.duplex) begin
            r.exp_rx  = v.resp & tm;
            r.exp_rcv = v.txd & tm;
            r.exp_lat = 2 * CLK_DIV * (v.txb + 1);
        end else begin
            r.exp_rx  = v.resp & rm;
            r.exp_rcv = (v.txd & tm) << v.rxb;
            r.exp_lat = 2 * CLK_DIV * (v.txb + PAUSE + v.rxb + 1);
        end
        return r;
    endfunction

    // Peripheral model state.
    bit     m_cpol, m_cpha;
    bit     miso [64];
    int     per_idx  = 0;
    longint rcv      = 0;
    int     rcv_n    = 0;
    int     done_cnt = 0;
    int     idle_tog = 0;
    int     edge_cyc [$];

    // Peripheral: samples COPI as it was just before each SCLK edge, drives CIPO per SPI mode.
    initial begin
        logic                prev_sclk = 1'b0;
        logic                prev_copi = 1'b0;
        logic [CS_COUNT-1:0] prev_csn  = '1;
        CIPO = 1'b0;
        forever begin
            @(negedge clk);
            if (done === 1'b1) done_cnt++;
            if (prev_csn == '1 && CS_n != '1) begin
                per_idx = 0; rcv = 0; rcv_n = 0;
                edge_cyc.delete();
                if (!m_cpha) CIPO = miso[0];
            end
            if (SCLK !== prev_sclk) begin
                if (CS_n == '1) begin
                    idle_tog++;
                end else begin
                    edge_cyc.push_back(cyc);
                    if (SCLK != m_cpol) begin
                        if (!m_cpha) begin
                            rcv = (rcv << 1) | longint'(prev_copi); rcv_n++;
                        end else if (per_idx < 64) begin
                            CIPO = miso[per_idx];
                        end
                    end else begin
                        if (m_cpha) begin
                            rcv = (rcv << 1) | longint'(prev_copi); rcv_n++;
                        end
                        per_idx++;
                        if (!m_cpha && per_idx < 64) CIPO = miso[per_idx];
                    end
                end
            end
            prev_sclk = SCLK;
            prev_copi = COPI;
            prev_csn  = CS_n;
        end
    end

    task automatic load_mode(input vec_t v);
        @(negedge clk);
        cpol = v.cpol; cpha = v.cpha;
        m_cpol = v.cpol; m_cpha = v.cpha;
        for (int k = 0; k < 64; k++) begin
            if (v.duplex)
                miso[k] = (k < v.txb) ? bit'((v.resp >> (v.txb - 1 - k)) & 1) : 1'b0;
            else if (k < v.txb)
                miso[k] = 1'b1;
            else if (k < v.txb + v.rxb)
                miso[k] = bit'((v.resp >> (v.rxb - 1 - (k - v.txb))) & 1);
            else
                miso[k] = 1'b0;
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic run_vec(input vec_t v, input int poke);
        int                  d0, t0, e, cs_bad;
        bit                  got;
        logic [CS_COUNT-1:0] exp_cs;
        load_mode(v);
        exp_cs = v.exp_err ? '1 : ~(CS_COUNT'(1) << v.cs);
        d0 = done_cnt; t0 = idle_tog; cs_bad = 0; got = 0;
        CS_in = v.cs; duplex = v.duplex;
        tx_bits = LEN_W'(v.txb); rx_bits = LEN_W'(v.rxb);
        data_tx = DATA_W'(v.txd);
        start_comm = 1'b1;
        e = cyc + 1;
        for (int k = 0; k < 1000; k++) begin
            @(negedge clk);
            if (k == 0) start_comm = 1'b0;
            if (poke > 0 && k == poke) begin
                start_comm = 1'b1; CS_in = ~v.cs; data_tx = ~data_tx; tx_bits = 3;
            end
            if (poke > 0 && k == poke + 1) start_comm = 1'b0;
            if (done) begin
                got = 1;
                break;
            end
            if (CS_n != exp_cs) cs_bad++;
        end
        chk({v.name, " done_seen"}, got, 1);
        chk({v.name, " latency"}, cyc - e, v.exp_lat);
        chk({v.name, " err"}, err, v.exp_err);
        chk({v.name, " data_rx"}, data_rx, v.exp_rx);
        chk({v.name, " cs_n_end"}, CS_n, 4'hF);
        chk({v.name, " busy_end"}, busy, 0);
        chk({v.name, " cs_n_during"}, cs_bad, 0);
        if (!v.exp_err) begin
            chk({v.name, " sclk_idle"}, SCLK, v.cpol);
            chk({v.name, " periph_rcv"}, rcv, v.exp_rcv);
            chk({v.name, " periph_bits"}, rcv_n, v.duplex ? v.txb : v.txb + v.rxb);
            chk({v.name, " sclk_edges"}, edge_cyc.size(), 2 * rcv_n);
            if (!v.duplex) begin
                if (edge_cyc.size() > 2 * v.txb)
                    chk({v.name, " pause_gap"}, edge_cyc[2*v.txb] - edge_cyc[2*v.txb-1],
                        CLK_DIV * (2 * PAUSE + 1));
                else
                    chk({v.name, " pause_gap"}, edge_cyc.size(), 2 * v.txb + 1);
            end
        end
        repeat (3) begin
            @(negedge clk);
            if (CS_n != '1) cs_bad++;
        end
        if (v.exp_err) begin
            chk({v.name, " no_sclk"}, idle_tog - t0, 0);
            chk({v.name, " no_cs"}, cs_bad, 0);
        end
        chk({v.name, " one_done"}, done_cnt - d0, 1);
    endtask

    vec_t tbl [9];

    initial begin
        vec_t v;
        int   d0;
        bit   hit;
        rst = 1'b1; start_comm = 1'b0; CS_in = '0; cpol = 1'b0; cpha = 1'b0;
        duplex = 1'b1; tx_bits = '0; rx_bits = '0; data_tx = '0;
        #1;
        chk("reset cs_n", CS_n, 4'hF);
        chk("reset sclk", SCLK, 0);
        chk("reset copi", COPI, 0);
        chk("reset data_rx", data_rx, 0);
        chk("reset busy", busy, 0);
        chk("reset done", done, 0);
        chk("reset err", err, 0);
        repeat (3) @(negedge clk);
        rst = 1'b0;

        tbl[0] = mk(0, 0, 0, 1,  8,  0, 'h00A5, 'h003C, 0, 'h003C,  36, 'h00A5,   "fd_mode0");
        tbl[1] = mk(1, 0, 0, 0,  8, 16, 'h005A, 'hBEEF, 0, 'hBEEF, 120, 'h5A0000, "seq_beef");
        tbl[2] = mk(2, 0, 0, 1,  0,  0, 'h1234, 'h0000, 1, 'hBEEF,   0, 0,        "err_tx0");
        tbl[3] = mk(2, 0, 0, 1, 17,  0, 'h1234, 'h0000, 1, 'hBEEF,   0, 0,        "err_tx17");
        tbl[4] = mk(1, 0, 0, 0,  4,  0, 'h000F, 'h0000, 1, 'hBEEF,   0, 0,        "err_rx0");
        tbl[5] = mk(1, 0, 0, 0,  4, 17, 'h000F, 'h0000, 1, 'hBEEF,   0, 0,        "err_rx17");
        tbl[6] = mk(3, 1, 1, 1, 16,  0, 'h1234, 'hCAFE, 0, 'hCAFE,  68, 'h1234,   "fd_mode3_16");
        tbl[7] = mk(2, 0, 1, 1,  1,  9, 'hFFFE, 'h0001, 0, 'h0001,   8, 'h0000,   "fd_tx1");
        tbl[8] = mk(0, 1, 0, 0, 16,  1, 'h8001, 'h0001, 0, 'h0001,  92, 'h10002,  "seq_rx1");
        for (int i = 0; i < 9; i++) run_vec(tbl[i], 0);

        // Random transfers over all modes and selects; every third one re-pokes start_comm.
        for (int i = 0; i < 16; i++) begin
            v.cs = 2'(i % 4); v.cpol = bit'((i >> 3) & 1); v.cpha = bit'((i >> 2) & 1);
            v.duplex = bit'($urandom % 2);
            v.txb = $urandom_range(1, DATA_W); v.rxb = $urandom_range(1, DATA_W);
            v.txd = longint'($urandom & 32'hFFFF); v.resp = longint'($urandom & 32'hFFFF);
            v.name = $sformatf("rnd%0d", i);
            v = model(v);
            run_vec(v, (i % 3 == 0) ? $urandom_range(2, v.exp_lat - 4) : 0);
        end

        // Asynchronous reset at bit 4 of a 16-bit transfer.
        v = model(mk(1, 0, 0, 1, 16, 0, 'hA5A5, 'h5A5A, 0, 0, 0, 0, "rst_mid"));
        load_mode(v);
        d0 = done_cnt; hit = 0;
        CS_in = v.cs; duplex = 1'b1; tx_bits = 16; data_tx = 16'hA5A5;
        start_comm = 1'b1;
        for (int k = 0; k < 400; k++) begin
            @(negedge clk);
            start_comm = 1'b0;
            if (per_idx >= 4) begin
                hit = 1;
                break;
            end
        end
        chk("rst_mid reached_bit4", hit, 1);
        #2 rst = 1'b1;
        #1;
        chk("rst_mid cs_n", CS_n, 4'hF);
        chk("rst_mid sclk", SCLK, 0);
        chk("rst_mid busy", busy, 0);
        chk("rst_mid data_rx", data_rx, 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (80) @(negedge clk);
        chk("rst_mid no_done", done_cnt - d0, 0);
        chk("rst_mid cs_idle", CS_n, 4'hF);
        run_vec(tbl[0], 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/spi_controller_mm.md
SPI_CONTROLLER_MM -- requirements
Module: spi_controller_mm

Interface
REQ-001 SHALL have parameter DATA_W, default 16, maximum shift-register width in bits.
REQ-002 SHALL have parameter LEN_W, default 5, width of the length inputs; it must satisfy 2**LEN_W > DATA_W.
REQ-003 SHALL have parameter CS_COUNT, default 4, number of peripheral chip selects.
REQ-004 SHALL have parameter CS_W, default 2, width of the peripheral select; equals log2(CS_COUNT).
REQ-005 SHALL have parameter CLK_DIV, default 2, SCLK half-period in clk cycles; minimum 1.
REQ-006 SHALL have parameter PAUSE, default 5, idle SCLK periods between the write and read phases in sequential mode.
REQ-007 SHALL have port clk, input, 1 bit: the single system clock; all logic is on its rising edge.
REQ-008 SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-009 SHALL have port start_comm, input, 1 bit: transfer request.
REQ-010 SHALL have port CS_in, input, CS_W bits: peripheral index.
REQ-011 SHALL have ports cpol and cpha, input, 1 bit each: SPI mode.
REQ-012 SHALL have port duplex, input, 1 bit: 1 = full-duplex, 0 = sequential write-pause-read.
REQ-013 SHALL have ports tx_bits and rx_bits, input, LEN_W bits each: bit counts.
REQ-014 SHALL have port data_tx, input, DATA_W bits: word to send, right-aligned.
REQ-015 SHALL have port CIPO, input, 1 bit: serial data from the peripheral.
REQ-016 SHALL have port SCLK, output, 1 bit: serial clock.
REQ-017 SHALL have port COPI, output, 1 bit: serial data to the peripheral.
REQ-018 SHALL have port CS_n, output, CS_COUNT bits: active-low, at most one bit low.
REQ-019 SHALL have port data_rx, output, DATA_W bits: received word, right-aligned, upper bits zero.
REQ-020 SHALL have ports busy, done and err, output, 1 bit each: status; done and err are single-cycle pulses.

Function
REQ-021 SHALL accept a request only in IDLE with start_comm=1 at a rising edge (E0), latching CS_in, cpol, cpha, duplex, tx_bits, rx_bits and data_tx at E0.
- start_comm while busy is ignored, with no effect on the transfer in progress.
REQ-022 SHALL reject the request at E0 when tx_bits=0, tx_bits>DATA_W, or (duplex=0 and rx_bits is 0 or >DATA_W).
- Response: err=1 and done=1 for one cycle after E0.
- CS_n and SCLK do not toggle; data_rx is unchanged.
REQ-023 SHALL use states IDLE -> SETUP -> WRITE -> (sequential only: PAUSE -> READ) -> HOLD -> IDLE.
REQ-024 SHALL drive CS_n[CS_in]=0 and busy=1 from E0 until the end of HOLD.
- SETUP lasts CLK_DIV cycles.
- HOLD lasts CLK_DIV cycles after the last SCLK edge.
REQ-025 SHALL hold SCLK at the registered cpol input while in IDLE and PAUSE.
- Each bit is one SCLK period: a leading edge and a trailing edge, each CLK_DIV cycles apart.
REQ-026 SHALL drive data MSB-first, starting at data_tx[tx_bits-1].
- cpha=0: COPI is valid from SETUP; CIPO is sampled on the leading edge; COPI shifts on the trailing edge.
- cpha=1: COPI shifts on the leading edge; CIPO is sampled on the trailing edge.
REQ-027 SHALL, in full-duplex, run tx_bits periods, sampling CIPO on each of them; rx_bits is ignored.
REQ-028 SHALL, in sequential mode, run tx_bits write periods, then PAUSE idle periods, then rx_bits read periods.
- COPI=0 during PAUSE and READ.
- CIPO is sampled only during READ.
REQ-029 SHALL shift sampled bits in at the LSB, loading data_rx with the zero-extended result in the done cycle.
REQ-030 SHALL, at the end of HOLD, assert done=1 for one cycle, set CS_n to all ones and busy=0 in that same cycle, and return to IDLE.
- A new start_comm is accepted on the next edge.
REQ-031 SHALL raise done at edge E0 + CLK_DIV*(2N+2).
- Full-duplex: N = tx_bits.
- Sequential: N = tx_bits + PAUSE + rx_bits.

Reset
REQ-032 SHALL, on rst=1 (asynchronously, including mid-transfer), abort any transfer and force state=IDLE, CS_n=all ones, SCLK=0, COPI=0, data_rx=0, busy=0, done=0 and err=0.
- No done pulse is issued for the aborted transfer.

Verification
REQ-033 SHALL test full-duplex with CLK_DIV=2, mode 0, CS_in=0, tx_bits=8, data_tx=0x00A5, and the peripheral model returning 0x3C.
- Required: the model receives 0xA5, data_rx=0x003C, done at E0+36, CS_n=4'b1110 throughout.
REQ-034 SHALL test sequential mode with tx_bits=8, rx_bits=16, data_tx=0x5A and peripheral data 0xBEEF.
- Required: data_rx=0xBEEF, PAUSE periods with SCLK at idle level, done at E0+120.
REQ-035 SHALL test all four cpol/cpha modes with CS_in cycling 0..3 and random data.
- Required: the correct CS_n bit is low, SCLK idles at cpol, and data matches in both directions.
REQ-036 SHALL test start_comm re-asserted at a random cycle during a transfer.
- Required: done timing and data are unchanged, and there is exactly one done pulse.
REQ-037 SHALL test tx_bits=0, then tx_bits=17.
- Required: err and done pulse one cycle after E0, with no CS_n or SCLK activity.
REQ-038 SHALL test rst=1 at bit 4 of a transfer.
- Required: CS_n=all ones immediately with no done pulse; a subsequent transfer completes correctly.
